spi_tx_arbiter: RTL and testbench

- Shares one SPIGate read address between NREQ internal byte producers. Each producer raises REQ with a data byte.
- The block grants producers round-robin and presents two bytes to the host on TXD: a header byte carrying the channel id, then the data byte.
- Sits on the SPIGate bus beside IOPort8/IOPort16 instances. Host writes to the same address control enable/abort.

---
 rtl/spi_tx_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_spi_tx_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_tx_arbiter
// Purpose  : Round-robin arbiter that lets NREQ internal byte producers share
//            one SPIGate read address. Each grant presents two bytes to the
//            host on txd: a header (0x80 | channel id), then the data byte
//            latched at grant time. Host writes to the same address control
//            enable (bit 0) and abort (bit 1).
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            address       - bus address this block answers on
//            addr          - current SPIGate address
//            rxd, rxe      - host write data / one-cycle write strobe
//            txe           - one-cycle strobe: gate captured txd
//            txd           - registered byte to host, 0x00 when not addressed
//            req, data     - per-channel request level / byte (8*i+7:8*i)
//            ack           - one-cycle pulse when a channel's byte delivered
//            busy          - high while a grant is in HDR or DAT
// Options  : SPI_TX_ARBITER_MASK_EN - adds an NREQ-bit channel mask register
//            at address+1 (reset all-ones, readable, writable).
// Revision : 1.0 - initial release
// ============================================================================
module spi_tx_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        address,
  input  logic [7:0]        addr,
  input  logic [7:0]        rxd,
  input  logic              rxe,
  input  logic              txe,
  output logic [7:0]        txd,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  output logic [NREQ-1:0]   ack,
  output logic              busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DAT  = 2'd2;

  logic [1:0]      r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic            r_en;
  logic [IDW-1:0]  r_id;
  logic [7:0]      r_byte;
  logic [7:0]      r_txd;
  logic [NREQ-1:0] r_ack;

  logic            w_hit;
  logic            w_ctrl_wr;
  logic            w_abort;
  logic            w_en_eff;
  logic            w_take;
  logic [NREQ-1:0] w_elig;
  logic            w_found;
  logic [IDW-1:0]  w_pick;
  logic [7:0]      w_cur;
  logic [7:0]      w_other_rd;
  logic [IDW-1:0]  w_next_ptr;
  logic [NREQ-1:0] w_ack_vec;
  logic [15:0]     w_rxd_ext;
  logic            w_unused;

  assign w_hit     = (addr == address);
  assign w_ctrl_wr = rxe & w_hit;
  assign w_abort   = w_ctrl_wr & rxd[1];
  // A same-cycle control write overrides the stored enable, so an en=0
  // write suppresses a grant being evaluated in that very cycle.
  assign w_en_eff  = w_ctrl_wr ? rxd[0] : r_en;
  assign w_take    = txe & w_hit;
  assign w_rxd_ext = {8'h00, rxd};

`ifdef SPI_TX_ARBITER_MASK_EN
  logic [NREQ-1:0] r_mask;
  logic            w_mhit;
  logic [15:0]     w_mask_ext;

  // address+1 wraps at 256 because the sum stays 8 bits wide.
  assign w_mhit     = (addr == 8'(address + 8'd1));
  assign w_mask_ext = 16'(r_mask);
  assign w_elig     = req & r_mask;
  assign w_other_rd = w_mhit ? w_mask_ext[7:0] : 8'h00;
  assign w_unused   = &{1'b0, w_rxd_ext[15:8], w_mask_ext[15:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '1;
    end else if (rxe && w_mhit) begin
      r_mask <= w_rxd_ext[NREQ-1:0];
    end
  end
`else
  assign w_elig     = req;
  assign w_other_rd = 8'h00;
  assign w_unused   = &{1'b0, w_rxd_ext};
`endif

  // First eligible channel at or after r_rr_ptr, wrapping modulo NREQ.
  // The sum is one bit wider than an id so 2*NREQ-2 never overflows.
  always_comb begin
    logic [IDW:0] w_sum;
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NREQ)) begin
        w_sum = w_sum - (IDW+1)'(NREQ);
      end
      if (!w_found && w_elig[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_cur = 8'h00;
    case (r_state)
      S_HDR:   w_cur = {1'b1, 7'(r_id)};
      S_DAT:   w_cur = r_byte;
      default: w_cur = 8'h00;
    endcase
  end

  assign w_next_ptr = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);
  assign w_ack_vec  = NREQ'(1) << r_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_en     <= 1'b1;
      r_id     <= '0;
      r_byte   <= 8'h00;
      r_txd    <= 8'h00;
      r_ack    <= '0;
    end else begin
      r_ack <= '0;
      r_txd <= w_hit ? w_cur : w_other_rd;

      if (w_ctrl_wr) begin
        r_en <= rxd[0];
      end

      case (r_state)
        S_IDLE: begin
          if (!w_abort && w_en_eff && w_found) begin
            r_id    <= w_pick;
            r_byte  <= data[{w_pick, 3'b000} +: 8];
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (w_take) begin
            r_state <= S_DAT;
          end
        end
        S_DAT: begin
          // Abort beats a same-cycle delivery: no ACK, pointer untouched.
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (w_take) begin
            r_ack    <= w_ack_vec;
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign txd  = r_txd;
  assign ack  = r_ack;
  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_tx_arbiter
// Purpose  : Directed self-checking bench for spi_tx_arbiter (NREQ=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_tx_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        address;
  logic [7:0]        addr;
  logic [7:0]        rxd;
  logic              rxe;
  logic              txe;
  logic [7:0]        txd;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   ack;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_tx_arbiter #(.NREQ(NREQ)) dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .addr    (addr),
    .rxd     (rxd),
    .rxe     (rxe),
    .txe     (txe),
    .txd     (txd),
    .req     (req),
    .data    (data),
    .ack     (ack),
    .busy    (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Enters HDR from IDLE: one edge to grant, one more for the header byte.
  task automatic grant(input int id);
    tick;
    chk("grant_busy", 16'(busy), 16'd1);
    chk("grant_ack_clear", 16'(ack), 16'd0);
    chk("grant_txd_idle", 16'(txd), 16'h00);
    tick;
    chk("hdr_txd", 16'(txd), 16'h80 | 16'(id));
  endtask

  // From HDR: TXE moves to DAT, data byte appears, second TXE delivers.
  task automatic finish(input int id, input logic [7:0] d);
    txe = 1'b1;
    tick;
    txe = 1'b0;
    chk("dat_busy", 16'(busy), 16'd1);
    chk("dat_no_ack", 16'(ack), 16'd0);
    tick;
    chk("dat_txd", 16'(txd), 16'(d));
    txe = 1'b1;
    tick;
    txe = 1'b0;
    chk("deliver_ack", 16'(ack), 16'(1 << id));
    chk("deliver_busy", 16'(busy), 16'd0);
  endtask

  task automatic do_reset;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_txd", 16'(txd), 16'h00);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_ack", 16'(ack), 16'd0);
    req = '0;
    txe = 1'b0;
    rxe = 1'b0;
    rxd = 8'h00;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_txd(input string tag, input logic [7:0] exp, input int max);
    for (int n = 0; n < max; n++) begin
      tick;
      if (txd === exp) break;
    end
    chk(tag, 16'(txd), 16'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    address = 8'h05;
    addr    = 8'h05;
    rxd     = 8'h00;
    rxe     = 1'b0;
    txe     = 1'b0;
    req     = '0;
    data    = '0;
    repeat (2) tick;
    rst = 1'b0;

    // Reset state and TXE while idle
    chk("reset_txd", 16'(txd), 16'h00);
    chk("reset_ack", 16'(ack), 16'd0);
    chk("reset_busy", 16'(busy), 16'd0);
    txe = 1'b1;
    tick;
    txe = 1'b0;
    tick;
    chk("idle_txe_txd", 16'(txd), 16'h00);
    chk("idle_txe_ack", 16'(ack), 16'd0);
    chk("idle_txe_busy", 16'(busy), 16'd0);

    // Single request on channel 2
    data = 32'h443C_2211;
    req  = 4'b0100;
    grant(2);
    finish(2, 8'h3C);
    req = '0;
    tick;
    chk("ack_width", 16'(ack), 16'd0);
    chk("post_txd", 16'(txd), 16'h00);

    // All requests held: grants rotate 0,1,2,3,0
    do_reset;
    data = 32'hD3D2_D1D0;
    req  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      grant(i % 4);
      finish(i % 4, 8'hD0 + 8'(i % 4));
    end
    req = '0;
    tick;

    // Abort colliding with TXE; pointer must remain at 0
    do_reset;
    data = 32'h8877_55A5;
    req  = 4'b0010;
    grant(1);
    txe = 1'b1;
    rxe = 1'b1;
    rxd = 8'h03;
    req = 4'b0110;
    tick;
    txe = 1'b0;
    rxe = 1'b0;
    rxd = 8'h00;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_ack", 16'(ack), 16'd0);
    grant(1);
    finish(1, 8'h55);
    req = '0;
    tick;

    // Enable control; en=0 write colliding with a grant evaluation
    req = 4'b0001;
    rxe = 1'b1;
    rxd = 8'h00;
    tick;
    rxe = 1'b0;
    chk("dis_same_cycle_busy", 16'(busy), 16'd0);
    tick;
    tick;
    chk("dis_busy", 16'(busy), 16'd0);
    chk("dis_txd", 16'(txd), 16'h00);
    rxe = 1'b1;
    rxd = 8'h01;
    tick;
    rxe = 1'b0;
    rxd = 8'h00;
    wait_txd("reenable_hdr", 8'h80, 4);
    finish(0, 8'hA5);
    req = '0;
    tick;

    // TXE off-address ignored, then async reset in DAT
    req = 4'b0010;
    grant(1);
    addr = 8'h07;
    txe  = 1'b1;
    tick;
    txe  = 1'b0;
    chk("miss_txd", 16'(txd), 16'h00);
    chk("miss_busy", 16'(busy), 16'd1);
    addr = 8'h05;
    tick;
    chk("miss_still_hdr", 16'(txd), 16'h81);
    txe = 1'b1;
    tick;
    txe = 1'b0;
    tick;
    chk("pre_rst_dat", 16'(txd), 16'h55);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_txd", 16'(txd), 16'h00);
    chk("async_rst_busy", 16'(busy), 16'd0);
    chk("async_rst_ack", 16'(ack), 16'd0);
    txe = 1'b1;
    tick;
    chk("in_rst_ack", 16'(ack), 16'd0);
    #2;
    rst = 1'b0;
    txe = 1'b0;
    grant(1);
    finish(1, 8'h55);
    req = '0;
    tick;

    // Channel mask at address+1
    do_reset;
    addr = 8'h06;
    rxe  = 1'b1;
    rxd  = 8'h0E;
    tick;
    rxe  = 1'b0;
    rxd  = 8'h00;
    addr = 8'h05;
    req  = 4'b0011;
`ifdef SPI_TX_ARBITER_MASK_EN
    grant(1);
    addr = 8'h06;
    tick;
    chk("mask_read", 16'(txd), 16'h0E);
    addr = 8'h05;
    tick;
    chk("mask_back_hdr", 16'(txd), 16'h81);
    finish(1, 8'h55);
`else
    grant(0);
    addr = 8'h06;
    tick;
    chk("nomask_read", 16'(txd), 16'h00);
    addr = 8'h05;
    tick;
    chk("nomask_back_hdr", 16'(txd), 16'h80);
    finish(0, 8'hA5);
`endif
    req = '0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
